sdram_pattern_tester: RTL and testbench

//  Parametrised SDRAM self-test master: writes a pattern to a word range, reads it back, compares.

---
 rtl/sdram_pattern_tester_pkg.sv | 19 +
 rtl/sdram_pattern_gen.sv | 33 +++
 rtl/sdram_pattern_tester.sv | 229 ++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pattern_tester_pkg.sv
// Shared definitions for the SDRAM pattern tester: pattern modes and FSM states.
package sdram_pattern_tester_pkg;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_NADDR = 2'd1;
  localparam logic [1:0] PAT_WALK1 = 2'd2;
  localparam logic [1:0] PAT_XOR   = 2'd3;

  localparam int unsigned ERR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test pattern P(a) for one word address; shared by write and check paths.
module sdram_pattern_gen
  import sdram_pattern_tester_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 25
) (
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_pattern_c
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_addr_ext;
  logic [SH_W-1:0]   w_shift;

  assign w_addr_ext = DATA_W'(i_addr);
  assign w_shift    = w_addr_ext[SH_W-1:0];

  always_comb begin
    o_pattern_c = w_addr_ext;
    case (i_mode)
      PAT_ADDR:  o_pattern_c = w_addr_ext;
      PAT_NADDR: o_pattern_c = ~w_addr_ext;
      PAT_WALK1: o_pattern_c = DATA_W'(1) << w_shift;
      PAT_XOR:   o_pattern_c = w_addr_ext ^ i_seed;
      default:   o_pattern_c = w_addr_ext;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test master: writes a pattern over a word range, reads it back with
// pipelined Avalon-MM reads and reports pass, error count and first failing address.
module sdram_pattern_tester
  import sdram_pattern_tester_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned MAX_RD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned        IF_W    = $clog2(MAX_RD + 1);
  localparam logic [IF_W-1:0]    MAX_IF  = IF_W'(MAX_RD);
  localparam logic [ADDR_W-1:0]  ONE_A   = ADDR_W'(1);
  localparam logic [ERR_W-1:0]   ERR_MAX = '1;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_mode, w_mode_nxt;
  logic [DATA_W-1:0]   r_seed, w_seed_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [ADDR_W-1:0]   r_len, w_len_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_write, w_write_nxt;
  logic                r_read, w_read_nxt;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt;
  logic [ADDR_W-1:0]   r_first, w_first_nxt;
  logic [ADDR_W-1:0]   r_wr_cnt, w_wr_cnt_nxt;
  logic [ADDR_W-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic [IF_W-1:0]     r_in_flight, w_in_flight_nxt;
  logic                r_chk_valid, w_chk_valid_nxt;
  logic [DATA_W-1:0]   r_chk_data, w_chk_data_nxt;
  logic [ADDR_W-1:0]   r_chk_addr, w_chk_addr_nxt;

  logic                w_wr_acc, w_rd_acc, w_rdv_ok, w_mismatch;
  logic [DATA_W-1:0]   w_wr_pat_c, w_chk_pat_c;

  // Write pattern follows the next-cycle address so writedata lands with it.
  sdram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_gen_wr (
    .i_mode      (w_mode_nxt),
    .i_seed      (w_seed_nxt),
    .i_addr      (w_addr_nxt),
    .o_pattern_c (w_wr_pat_c)
  );

  sdram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_gen_chk (
    .i_mode      (r_mode),
    .i_seed      (r_seed),
    .i_addr      (r_chk_addr),
    .o_pattern_c (w_chk_pat_c)
  );

  assign w_wr_acc   = r_write & ~avm_waitrequest;
  assign w_rd_acc   = r_read & ~avm_waitrequest;
  assign w_rdv_ok   = avm_readdatavalid & (r_in_flight != '0);
  assign w_mismatch = r_chk_valid & (r_chk_data != w_chk_pat_c);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_seed_nxt      = r_seed;
    w_base_nxt      = r_base;
    w_len_nxt       = r_len;
    w_addr_nxt      = r_addr;
    w_write_nxt     = r_write;
    w_read_nxt      = r_read;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_pass_nxt      = r_pass;
    w_err_nxt       = r_err;
    w_first_nxt     = r_first;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_rd_cnt_nxt    = r_rd_cnt + ADDR_W'(w_rd_acc);
    w_in_flight_nxt = r_in_flight + IF_W'(w_rd_acc) - IF_W'(w_rdv_ok);
    w_chk_valid_nxt = w_rdv_ok;
    w_chk_data_nxt  = avm_readdata;
    w_chk_addr_nxt  = r_chk_addr;

    // Compare stage runs one cycle behind readdatavalid, in response order.
    if (r_chk_valid) begin
      w_chk_addr_nxt = r_chk_addr + ONE_A;
      if (w_mismatch) begin
        if (r_err == '0)     w_first_nxt = r_chk_addr;
        if (r_err != ERR_MAX) w_err_nxt  = r_err + ERR_W'(1);
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mode_nxt      = mode;
          w_seed_nxt      = seed;
          w_base_nxt      = base_addr;
          w_len_nxt       = len;
          w_err_nxt       = '0;
          w_first_nxt     = '0;
          w_pass_nxt      = 1'b0;
          w_wr_cnt_nxt    = '0;
          w_rd_cnt_nxt    = '0;
          w_in_flight_nxt = '0;
          w_chk_addr_nxt  = base_addr;
          if (len != '0) begin
            w_state_nxt = ST_WRITE;
            w_busy_nxt  = 1'b1;
            w_write_nxt = 1'b1;
            w_addr_nxt  = base_addr;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (w_wr_acc) begin
          w_wr_cnt_nxt = r_wr_cnt + ONE_A;
          if (r_wr_cnt + ONE_A == r_len) begin
            w_state_nxt = ST_READ;
            w_write_nxt = 1'b0;
            w_read_nxt  = 1'b1;
            w_addr_nxt  = r_base;
          end else begin
            w_addr_nxt = r_addr + ONE_A;
          end
        end
      end
      ST_READ: begin
        if (w_rd_acc) w_addr_nxt = r_addr + ONE_A;
        // A stalled read stays up: in_flight cannot grow until it is accepted.
        if (w_rd_cnt_nxt == r_len) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_read_nxt = (w_in_flight_nxt < MAX_IF);
        end
      end
      ST_DRAIN: begin
        if ((r_in_flight == '0) && !r_chk_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_pass_nxt  = (r_err == '0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= '0;
      r_seed      <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_first     <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_in_flight <= '0;
      r_chk_valid <= 1'b0;
      r_chk_data  <= '0;
      r_chk_addr  <= '0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_seed      <= w_seed_nxt;
      r_base      <= w_base_nxt;
      r_len       <= w_len_nxt;
      r_addr      <= w_addr_nxt;
      r_write     <= w_write_nxt;
      r_read      <= w_read_nxt;
      r_wdata     <= w_write_nxt ? w_wr_pat_c : '0;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_err       <= w_err_nxt;
      r_first     <= w_first_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_in_flight <= w_in_flight_nxt;
      r_chk_valid <= w_chk_valid_nxt;
      r_chk_data  <= w_chk_data_nxt;
      r_chk_addr  <= w_chk_addr_nxt;
    end
  end

  assign avm_address    = r_addr;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_read       = r_read;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench: an Avalon slave model with stalls, latency and corruption;
// expected writes, reads and results are queued and checked by a negedge monitor.
module tb_sdram_pattern_tester;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned MAX_RD = 4;
  localparam longint      ASPACE = 64'd33554432;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = '0;
  logic [DATA_W-1:0] seed = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] len = '0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_read;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic              avm_waitrequest = 1'b0;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  always #5 clk = ~clk;

  sdram_pattern_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_RD(MAX_RD)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .len(len),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;
  typedef struct { int errs; logic [ADDR_W-1:0] first; logic pass; } res_t;
  typedef struct { logic [DATA_W-1:0] data; int due; } resp_t;

  wr_exp_t           wr_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  res_t              res_q[$];
  resp_t             resp_q[$];
  logic [DATA_W-1:0] mem[int];
  logic [DATA_W-1:0] corrupt[int];

  int checks = 0, failures = 0;
  int lat = 1, stall_mode = 0, cyc = 0;
  int tb_inflight = 0, max_inflight = 0, done_cnt = 0;
  bit track = 1'b1;
  bit prev_stalled = 1'b0, prev_done = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic [1:0]        prev_req;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pattern rules expressed as plain arithmetic on the word address.
  function automatic logic [DATA_W-1:0] ref_pat(input int m, input int s, input longint a);
    longint lo;
    lo = a % 65536;
    case (m)
      0:       return DATA_W'(lo);
      1:       return DATA_W'(65535 - lo);
      2:       return DATA_W'(64'd1 << (a % 16));
      default: return DATA_W'(lo) ^ DATA_W'(s);
    endcase
  endfunction

  // Slave model and monitor: drive the next edge's slave inputs, then score it.
  always @(negedge clk) begin
    bit stalled, rdv_now, rd_acc;
    logic [DATA_W-1:0] d;
    wr_exp_t we;
    res_t    re;
    cyc++;
    case (stall_mode)
      1:       avm_waitrequest = cyc[0];
      2:       avm_waitrequest = ($urandom % 3 == 0);
      default: avm_waitrequest = 1'b0;
    endcase
    stalled = avm_waitrequest;
    rdv_now = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      avm_readdata      = resp_q[0].data;
      avm_readdatavalid = 1'b1;
      rdv_now           = 1'b1;
      void'(resp_q.pop_front());
    end else begin
      avm_readdata      = DATA_W'($urandom);
      avm_readdatavalid = 1'b0;
    end

    if (avm_read || avm_write) check("rd_wr_exclusive", avm_read & avm_write, 0);
    if (prev_stalled) begin
      check("hold_req", {avm_read, avm_write}, prev_req);
      check("hold_addr", avm_address, prev_addr);
      if (prev_req[0]) check("hold_wdata", avm_writedata, prev_data);
    end
    prev_stalled = (avm_read || avm_write) && stalled;
    prev_req     = {avm_read, avm_write};
    prev_addr    = avm_address;
    prev_data    = avm_writedata;

    if (avm_write && !stalled) begin
      if (wr_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        we = wr_q.pop_front();
        check("write_addr", avm_address, we.addr);
        check("write_data", avm_writedata, we.data);
      end
      mem[int'(avm_address)] = avm_writedata;
    end
    rd_acc = avm_read && !stalled;
    if (rd_acc) begin
      if (rd_q.size() == 0) check("unexpected_read", 1, 0);
      else check("read_addr", avm_address, rd_q.pop_front());
      d = mem.exists(int'(avm_address)) ? mem[int'(avm_address)] : '0;
      if (corrupt.exists(int'(avm_address))) d = d ^ corrupt[int'(avm_address)];
      resp_q.push_back('{data: d, due: cyc + lat});
    end
    if (track) begin
      if (tb_inflight == int'(MAX_RD)) check("read_low_when_full", avm_read, 0);
      tb_inflight = tb_inflight + int'(rd_acc) - int'(rdv_now);
      if (tb_inflight > max_inflight) max_inflight = tb_inflight;
      if (rd_acc) check("inflight_bound", tb_inflight <= int'(MAX_RD), 1);
    end

    if (done) begin
      check("done_single_pulse", prev_done, 0);
      if (res_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        re = res_q.pop_front();
        check("err_count", err_count, re.errs);
        check("first_err_addr", first_err_addr, re.first);
        check("pass", pass, re.pass);
        check("busy_at_done", busy, 0);
        check("writes_left", wr_q.size(), 0);
        check("reads_left", rd_q.size(), 0);
      end
      done_cnt++;
    end
    prev_done = done;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"}, {avm_write, avm_read, busy, done, pass}, 0);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_wdata"}, avm_writedata, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_first"}, first_err_addr, 0);
  endtask

  task automatic clear_sb();
    wr_q.delete(); rd_q.delete(); res_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Queue the expected traffic and result, launch one test and wait for done.
  task automatic run_test(input int m, input int s, input longint b, input int l,
                          input int latency, input int stl);
    int errs, target, n;
    longint a, first;
    errs = 0; first = 0;
    lat = latency; stall_mode = stl; max_inflight = 0;
    for (int i = 0; i < l; i++) begin
      a = (b + i) % ASPACE;
      wr_q.push_back('{addr: ADDR_W'(a), data: ref_pat(m, s, a)});
      rd_q.push_back(ADDR_W'(a));
      if (corrupt.exists(int'(a)) && corrupt[int'(a)] != '0) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
    res_q.push_back('{errs: errs, first: ADDR_W'(first), pass: (errs == 0)});
    target = done_cnt + 1;
    @(negedge clk);
    mode = 2'(m); seed = DATA_W'(s); base_addr = ADDR_W'(b); len = ADDR_W'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); seed = DATA_W'($urandom);
    base_addr = ADDR_W'($urandom); len = ADDR_W'($urandom);
    check("busy_after_start", busy, 1);
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk); n++;
    end
    if (done_cnt < target) begin
      check("done_timeout", 0, 1);
      track = 1'b0; stall_mode = 0;
      do_reset();
      clear_sb(); resp_q.delete(); tb_inflight = 0; track = 1'b1;
    end
    repeat (3) @(negedge clk);
    corrupt.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Ideal slave, address pattern.
    run_test(0, 0, 'h100, 8, 1, 0);
    check("pass_held", pass, 1);
    // Alternate-cycle stalls, walking ones across the 16-bit wrap.
    run_test(2, 0, 'h100, 20, 1, 1);
    // Two corrupted words under the XOR pattern.
    corrupt[32'h103] = 16'h0001;
    corrupt[32'h105] = 16'h0001;
    run_test(3, 'hA5A5, 'h100, 8, 1, 0);
    check("pass_held_low", pass, 0);
    // Long read latency fills the pipeline.
    run_test(1, 0, 'h400, 16, 10, 0);
    check("max_inflight_reached", max_inflight, MAX_RD);
    // Address space wrap.
    run_test(0, 0, ASPACE - 2, 4, 1, 0);

    // Zero-length test: done two cycles after start, no traffic.
    res_q.push_back('{errs: 0, first: '0, pass: 1'b1});
    @(negedge clk); len = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("len0_done_early", done, 0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_pass", pass, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of the read phase with reads outstanding.
    lat = 10; stall_mode = 0;
    for (int i = 0; i < 16; i++) begin
      wr_q.push_back('{addr: ADDR_W'('h200 + i), data: ref_pat(0, 0, 'h200 + i)});
      rd_q.push_back(ADDR_W'('h200 + i));
    end
    @(negedge clk); mode = 2'd0; base_addr = ADDR_W'('h200); len = ADDR_W'(16); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (tb_inflight != 3 && n < 500) begin @(negedge clk); n++; end
    check("reached_3_inflight", tb_inflight, 3);
    track = 1'b0;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_all_zero("midreset");
    clear_sb();
    n = 0;
    while (resp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("late_rdv_no_err", err_count, 0);
    check("late_rdv_idle", {busy, done}, 0);
    tb_inflight = 0; track = 1'b1;

    // Randomized tests with random stalls, latency and corruption.
    for (int t = 0; t < 10; t++) begin
      int m, s, l;
      longint b;
      m = int'($urandom % 4);
      s = int'($urandom % 65536);
      b = ($urandom % 4 == 0) ? ASPACE - 1 - longint'($urandom % 8) : longint'($urandom % 4096);
      l = 1 + int'($urandom % 24);
      for (int i = 0; i < l; i++)
        if ($urandom % 6 == 0) corrupt[int'((b + i) % ASPACE)] = DATA_W'(1) << ($urandom % 16);
      run_test(m, s, b, l, 1 + int'($urandom % 12), int'($urandom % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
